// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an external single-port S-box RAM.
// Fills S[i]=i, then (unless init_only) runs the KSA swap loop
//   j = j + S[i] + key[i mod KEY_LEN]; swap(S[i], S[j])
// using one RAM access per cycle. All outputs leave flops: the output decode
// runs on the next-state values so each output is valid during its state.
module ksa_engine #(
   parameter int DATA_W  = 8,
   parameter int KEY_LEN = 3
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      init_only,
   input  logic [KEY_LEN*DATA_W-1:0] key,
   output logic [DATA_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      mem_wren,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output logic                      done
);

   // Key index width; a one-word key still gets a 1-bit counter that is always 0.
   localparam int                KI_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
   localparam logic [DATA_W-1:0] I_LAST  = {DATA_W{1'b1}};
   localparam logic [KI_W-1:0]   KI_LAST = KI_W'(KEY_LEN - 1);

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_INIT    = 4'd1,
      ST_KS_RD_I = 4'd2,
      ST_KS_LD_I = 4'd3,
      ST_KS_RD_J = 4'd4,
      ST_KS_LD_J = 4'd5,
      ST_KS_WR_I = 4'd6,
      ST_KS_WR_J = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

   state_t                    state_q, state_d;
   logic [DATA_W-1:0]         i_q, i_d;
   logic [DATA_W-1:0]         j_q, j_d;
   logic [DATA_W-1:0]         si_q, si_d;
   logic [DATA_W-1:0]         sj_q, sj_d;
   logic [KI_W-1:0]           kidx_q, kidx_d;
   logic [KEY_LEN*DATA_W-1:0] key_q, key_d;
   logic                      init_only_q, init_only_d;
   logic [DATA_W-1:0]         mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
   logic                      mem_wren_q, mem_wren_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   // Select key word idx; word 0 is the most significant word of the key bus.
   function automatic logic [DATA_W-1:0] key_word(
      input logic [KEY_LEN*DATA_W-1:0] k,
      input logic [KI_W-1:0]           idx
   );
      logic [DATA_W-1:0] w;
      w = k[KEY_LEN*DATA_W-1 -: DATA_W];
      for (int n = 1; n < KEY_LEN; n++) begin
         if (idx == KI_W'(n)) begin
            w = k[(KEY_LEN-n)*DATA_W-1 -: DATA_W];
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

   // Next-state and datapath: fill sweep, then the six-cycle read/read/swap loop per i.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      j_d         = j_q;
      si_d        = si_q;
      sj_d        = sj_q;
      kidx_d      = kidx_q;
      key_d       = key_q;
      init_only_d = init_only_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Key and mode are captured here so later changes cannot disturb the run.
               key_d       = key;
               init_only_d = init_only;
               i_d         = '0;
               j_d         = '0;
               kidx_d      = '0;
               state_d     = ST_INIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_INIT: begin
            if (i_q == I_LAST) begin
               i_d    = '0;
               j_d    = '0;
               kidx_d = '0;
               if (init_only_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_KS_RD_I;
               end
            end else begin
               i_d     = i_q + DATA_W'(1);
               state_d = ST_INIT;
            end
         end
         ST_KS_RD_I: begin
            state_d = ST_KS_LD_I;
         end
         ST_KS_LD_I: begin
            // Sum wraps naturally at DATA_W bits, i.e. modulo the S-box depth.
            si_d    = mem_rdata;
            j_d     = j_q + mem_rdata + key_word(key_q, kidx_q);
            state_d = ST_KS_RD_J;
         end
         ST_KS_RD_J: begin
            state_d = ST_KS_LD_J;
         end
         ST_KS_LD_J: begin
            sj_d    = mem_rdata;
            state_d = ST_KS_WR_I;
         end
         ST_KS_WR_I: begin
            state_d = ST_KS_WR_J;
         end
         ST_KS_WR_J: begin
            // Separate wrapping counter: KEY_LEN need not divide the S-box depth.
            if (kidx_q == KI_LAST) begin
               kidx_d = '0;
            end else begin
               kidx_d = kidx_q + KI_W'(1);
            end
            if (i_q == I_LAST) begin
               state_d = ST_DONE;
            end else begin
               i_d     = i_q + DATA_W'(1);
               state_d = ST_KS_RD_I;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every RAM strobe comes straight from a flop.
   always_comb begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_wren_d  = 1'b0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      case (state_d)
         ST_IDLE: begin
            busy_d = 1'b0;
         end
         ST_INIT: begin
            mem_addr_d  = i_d;
            mem_wdata_d = i_d;
            mem_wren_d  = 1'b1;
         end
         ST_KS_RD_I: begin
            mem_addr_d = i_d;
         end
         ST_KS_LD_I: begin
            mem_addr_d = i_d;
         end
         ST_KS_RD_J: begin
            mem_addr_d = j_d;
         end
         ST_KS_LD_J: begin
            mem_addr_d = j_d;
         end
         ST_KS_WR_I: begin
            // When i==j both writes carry the same word to the same address.
            mem_addr_d  = i_d;
            mem_wdata_d = sj_d;
            mem_wren_d  = 1'b1;
         end
         ST_KS_WR_J: begin
            mem_addr_d  = j_d;
            mem_wdata_d = si_d;
            mem_wren_d  = 1'b1;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         si_q        <= '0;
         sj_q        <= '0;
         kidx_q      <= '0;
         key_q       <= '0;
         init_only_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wren_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         si_q        <= si_d;
         sj_q        <= sj_d;
         kidx_q      <= kidx_d;
         key_q       <= key_d;
         init_only_q <= init_only_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wren_q  <= mem_wren_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wren  = mem_wren_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ksa_engine.sv
// tb_ksa_engine: scoreboard bench for ksa_engine.
// Three instances: A (DATA_W=2, KEY_LEN=1), B (DATA_W=2, KEY_LEN=2), C (DATA_W=8, KEY_LEN=3),
// each with its own behavioural sync RAM. The stimulus process pushes the expected
// result of a run (done latency, write-strobe count, final RAM image); one monitor
// per instance pops and compares whenever that instance pulses done.
module tb_ksa_engine;

   typedef struct packed {
      logic [31:0]       cycles;
      logic [31:0]       wrens;
      logic [255:0][7:0] ram;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   logic scr = 1'b0;

   // Instance A signals
   logic       rst_a = 1'b0, start_a = 1'b0, init_a = 1'b0;
   logic [1:0] key_a = 2'd0;
   logic [1:0] addr_a, wdata_a, rdata_a;
   logic       wren_a, busy_a, done_a;
   logic [1:0] ram_a [4];

   // Instance B signals
   logic       rst_b = 1'b0, start_b = 1'b0, init_b = 1'b0;
   logic [3:0] key_b = 4'd0;
   logic [1:0] addr_b, wdata_b, rdata_b;
   logic       wren_b, busy_b, done_b;
   logic [1:0] ram_b [4];

   // Instance C signals
   logic        rst_c = 1'b0, start_c = 1'b0, init_c = 1'b0;
   logic [23:0] key_c = 24'd0;
   logic [7:0]  addr_c, wdata_c, rdata_c;
   logic        wren_c, busy_c, done_c;
   logic [7:0]  ram_c [256];

   ksa_engine #(.DATA_W(2), .KEY_LEN(1)) u_a (
      .clk(clk), .reset_n(rst_a), .start(start_a), .init_only(init_a), .key(key_a),
      .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_a), .mem_rdata(rdata_a),
      .busy(busy_a), .done(done_a)
   );

   ksa_engine #(.DATA_W(2), .KEY_LEN(2)) u_b (
      .clk(clk), .reset_n(rst_b), .start(start_b), .init_only(init_b), .key(key_b),
      .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_b), .mem_rdata(rdata_b),
      .busy(busy_b), .done(done_b)
   );

   ksa_engine #(.DATA_W(8), .KEY_LEN(3)) u_c (
      .clk(clk), .reset_n(rst_c), .start(start_c), .init_only(init_c), .key(key_c),
      .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_wren(wren_c), .mem_rdata(rdata_c),
      .busy(busy_c), .done(done_c)
   );

   // RAM for A: scramble on request, else DUT write; one-cycle read latency.
   always @(posedge clk) begin
      if (scr) begin
         for (int k = 0; k < 4; k++) ram_a[k] <= 2'(k + 1);
      end else if (wren_a) begin
         ram_a[addr_a] <= wdata_a;
      end
      rdata_a <= ram_a[addr_a];
   end

   // RAM for B.
   always @(posedge clk) begin
      if (scr) begin
         for (int k = 0; k < 4; k++) ram_b[k] <= 2'(k + 3);
      end else if (wren_b) begin
         ram_b[addr_b] <= wdata_b;
      end
      rdata_b <= ram_b[addr_b];
   end

   // RAM for C.
   always @(posedge clk) begin
      if (scr) begin
         for (int k = 0; k < 256; k++) ram_c[k] <= 8'(165 ^ k);
      end else if (wren_c) begin
         ram_c[addr_c] <= wdata_c;
      end
      rdata_c <= ram_c[addr_c];
   end

   task automatic check_u(input string nm, input string what,
                          input longint unsigned got, input longint unsigned want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, what, got, want);
      end
   endtask

   function automatic logic [255:0][7:0] ram4(input int a, input int b, input int c, input int d);
      logic [255:0][7:0] r;
      r    = '0;
      r[0] = 8'(a);
      r[1] = 8'(b);
      r[2] = 8'(c);
      r[3] = 8'(d);
      return r;
   endfunction

   // Plain software KSA: S[i]=i, then j=(j+S[i]+key[i%kl]) mod n, swap.
   function automatic logic [255:0][7:0] ref_ksa(input int n, input int dw, input int kl,
                                                 input logic [23:0] k, input bit fill_only);
      int s [256];
      int j, kw, t;
      logic [255:0][7:0] r;
      r = '0;
      j = 0;
      for (int i = 0; i < n; i++) s[i] = i;
      if (!fill_only) begin
         for (int i = 0; i < n; i++) begin
            kw   = int'((k >> (dw * (kl - 1 - (i % kl)))) & 24'(n - 1));
            j    = (j + s[i] + kw) % n;
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
         end
      end
      for (int i = 0; i < n; i++) r[i] = 8'(s[i]);
      return r;
   endfunction

   function automatic exp_t mk_exp(input int cyc, input int wr, input logic [255:0][7:0] r);
      exp_t e;
      e.cycles = 32'(cyc);
      e.wrens  = 32'(wr);
      e.ram    = r;
      return e;
   endfunction

   task automatic push_exp(input int id, input exp_t e);
      case (id)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   function automatic int qsize(input int id);
      case (id)
         0:       return q_a.size();
         1:       return q_b.size();
         default: return q_c.size();
      endcase
   endfunction

   task automatic pop_exp(input int id, output exp_t e);
      case (id)
         0:       e = q_a.pop_front();
         1:       e = q_b.pop_front();
         default: e = q_c.pop_front();
      endcase
   endtask

   task automatic probe(input int id, output logic b, output logic d, output logic w,
                        output logic s, output logic r);
      case (id)
         0:       begin b = busy_a; d = done_a; w = wren_a; s = start_a; r = rst_a; end
         1:       begin b = busy_b; d = done_b; w = wren_b; s = start_b; r = rst_b; end
         default: begin b = busy_c; d = done_c; w = wren_c; s = start_c; r = rst_c; end
      endcase
   endtask

   function automatic logic [255:0][7:0] snap(input int id);
      logic [255:0][7:0] v;
      v = '0;
      case (id)
         0:       for (int k = 0; k < 4; k++) v[k] = {6'd0, ram_a[k]};
         1:       for (int k = 0; k < 4; k++) v[k] = {6'd0, ram_b[k]};
         default: for (int k = 0; k < 256; k++) v[k] = ram_c[k];
      endcase
      return v;
   endfunction

   // Monitor: counts cycles from the start-sampling edge, compares on done.
   task automatic monitor(input int id, input string nm);
      logic b, d, w, s, r;
      bit run, post;
      int unsigned cnt, wc, gaps;
      int bad;
      exp_t e;
      logic [255:0][7:0] got;
      run = 1'b0; post = 1'b0; cnt = 0; wc = 0; gaps = 0;
      forever begin
         @(negedge clk);
         probe(id, b, d, w, s, r);
         if (post) begin
            post = 1'b0;
            check_u(nm, "idle_after_done", {b, d}, 0);
         end else if (run) begin
            cnt++;
            if (w) wc++;
            if (!b) gaps++;
            if (d) begin
               run  = 1'b0;
               post = 1'b1;
               check_u(nm, "result_pending", (qsize(id) > 0) ? 1 : 0, 1);
               if (qsize(id) > 0) begin
                  pop_exp(id, e);
                  got = snap(id);
                  check_u(nm, "done_latency", cnt, e.cycles);
                  check_u(nm, "wren_cycles", wc, e.wrens);
                  check_u(nm, "busy_low_cycles", gaps, 0);
                  bad = -1;
                  for (int k = 0; k < 256; k++) begin
                     if (bad < 0 && got[k] !== e.ram[k]) bad = k;
                  end
                  n_checks++;
                  if (bad >= 0) begin
                     n_fail++;
                     $display("FAIL %s.ram[%0d]: got %0h, expected %0h", nm, bad, got[bad], e.ram[bad]);
                  end
               end
            end else if (cnt > 4000) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s.timeout: %0d cycles without done, expected at most 1793", nm, cnt);
               run = 1'b0;
            end
         end else begin
            check_u(nm, "idle_quiet", {d, w}, 0);
         end
         if (!r) begin
            run  = 1'b0;
            post = 1'b0;
         end else if (s && !b && !run) begin
            run  = 1'b1;
            cnt  = 0;
            wc   = 0;
            gaps = 0;
         end
      end
   endtask

   task automatic scramble();
      @(posedge clk); #2;
      scr = 1'b1;
      @(posedge clk); #2;
      scr = 1'b0;
   endtask

   // One-cycle start pulse; key and mode are flipped right after to prove they were latched.
   task automatic launch(input int id, input bit io, input logic [23:0] k);
      @(posedge clk); #2;
      case (id)
         0:       begin start_a = 1'b1; init_a = io; key_a = k[1:0]; end
         1:       begin start_b = 1'b1; init_b = io; key_b = k[3:0]; end
         default: begin start_c = 1'b1; init_c = io; key_c = k; end
      endcase
      @(posedge clk); #2;
      case (id)
         0:       begin start_a = 1'b0; init_a = ~io; key_a = ~k[1:0]; end
         1:       begin start_b = 1'b0; init_b = ~io; key_b = ~k[3:0]; end
         default: begin start_c = 1'b0; init_c = ~io; key_c = ~k; end
      endcase
   endtask

   task automatic wait_drain(input int id, input string nm, input int budget);
      int c;
      c = 0;
      while (qsize(id) != 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      check_u(nm, "pending_after_wait", qsize(id), 0);
      repeat (3) @(posedge clk);
   endtask

   initial begin
      fork
         monitor(0, "A");
         monitor(1, "B");
         monitor(2, "C");
      join_none
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0][7:0] ident;
      ident = '0;
      for (int k = 0; k < 256; k++) ident[k] = 8'(k);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_u("A", "reset_outputs", {busy_a, done_a, wren_a, addr_a, wdata_a}, 0);
      check_u("B", "reset_outputs", {busy_b, done_b, wren_b, addr_b, wdata_b}, 0);
      check_u("C", "reset_outputs", {busy_c, done_c, wren_c, addr_c, wdata_c}, 0);
      @(posedge clk); #2;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

      // Test 1: N=4, key=0 -> {0,2,3,1}, done at +29, 4+2*4 writes
      scramble();
      push_exp(0, mk_exp(29, 12, ram4(0, 2, 3, 1)));
      launch(0, 1'b0, 24'h0);
      wait_drain(0, "A", 100);

      // Test 2: N=4, key words 01,10 -> {0,3,2,1}; key wrap and i==j at i=2
      scramble();
      push_exp(1, mk_exp(29, 12, ram4(0, 3, 2, 1)));
      launch(1, 1'b0, 24'h6);
      wait_drain(1, "B", 100);

      // Test 3: N=256 fill only -> identity, done at +257, only 256 writes
      scramble();
      push_exp(2, mk_exp(257, 256, ident));
      launch(2, 1'b1, 24'h000249);
      wait_drain(2, "C", 400);

      // Test 4: N=256 full KSA with key 00 02 49, done at +1793
      scramble();
      push_exp(2, mk_exp(1793, 768, ref_ksa(256, 8, 3, 24'h000249, 1'b0)));
      launch(2, 1'b0, 24'h000249);
      wait_drain(2, "C", 2500);

      // Test 5: second start pulse mid-run (with a different key and mode) is ignored
      scramble();
      push_exp(0, mk_exp(29, 12, ram4(0, 2, 3, 1)));
      launch(0, 1'b0, 24'h0);
      repeat (8) @(posedge clk);
      #2;
      start_a = 1'b1; init_a = 1'b1; key_a = 2'b11;
      @(posedge clk); #2;
      start_a = 1'b0;
      wait_drain(0, "A", 100);

      // Test 6: one-cycle reset inside the KS loop, then a clean rerun of test 1
      scramble();
      launch(0, 1'b0, 24'h1);
      repeat (8) @(posedge clk);
      #2;
      rst_a = 1'b0;
      @(posedge clk); #2;
      check_u("A", "abort_outputs", {busy_a, done_a, wren_a}, 0);
      rst_a = 1'b1;
      scramble();
      push_exp(0, mk_exp(29, 12, ram4(0, 2, 3, 1)));
      launch(0, 1'b0, 24'h0);
      wait_drain(0, "A", 100);

      repeat (5) @(posedge clk);
      for (int q = 0; q < 3; q++) check_u("end", "queue_empty", qsize(q), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
